i2s_tx: RTL
===========

# i2s_tx

Audio output serializer downstream of `voice_controller`. It latches the signed 24-bit `o_mixed_sample` once per audio frame and pulses a one-cycle strobe so the mixer can advance to the next sample. It emits a Philips-format I2S stream (BCLK, LRCLK, SDATA) with the mono sample duplicated on the left and right channels, for the external DAC. All outputs are registered and generated from `i_clk`; there is no second clock domain.

## Interface
- `SAMPLE_W`, default 24: sample width; must be less than or equal to `SLOT_W`.
- `SLOT_W`, default 32: BCLK periods per channel slot.
- `CLK_DIV`, default 8: `i_clk` cycles per BCLK half-period; must be at least 1. At 50 MHz this gives BCLK = 3.125 MHz and fs ≈ 48.83 kHz.

Ports:
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  synchronous, active-low reset.
- `i_sample`  in  `SAMPLE_W`  signed mixed sample, two's complement.
- `i_mute`  in  1  when high, the next latched sample is forced to 0.
- `o_sample_strobe`  out  1  one-cycle pulse at each frame start; `i_sample` is captured on that edge.
- `o_bclk`  out  1  I2S bit clock.
- `o_lrclk`  out  1  word select; 0 = left, 1 = right.
- `o_sdata`  out  1  serial data, MSB first.

## Operation
- Internal state:
  - `div_cnt`, range 0..`CLK_DIV`-1.
  - `bit_cnt`, range 0..2·`SLOT_W`-1, 6 bits at default.
  - `hold`, a `SAMPLE_W`-bit sample register.
- Divider:
  - When `div_cnt == CLK_DIV-1`, `div_cnt` returns to 0 and `o_bclk` toggles; otherwise `div_cnt` increments.
  - A toggle with `o_bclk == 1` beforehand is a *fall event*.
- On each fall event:
  - `bit_cnt` increments, wrapping 2·`SLOT_W`-1 → 0.
  - `o_lrclk` becomes the MSB of the new `bit_cnt` (`bit_cnt >= SLOT_W`).
  - `o_sdata` is driven from the new `bit_cnt`:
    - `bit_cnt` 1..`SAMPLE_W`: `hold[SAMPLE_W - bit_cnt]` (left slot).
    - `bit_cnt` `SLOT_W`+1..`SLOT_W`+`SAMPLE_W`: `hold[SLOT_W + SAMPLE_W - bit_cnt]` (right slot).
    - All other values: 0.
  - Data therefore trails LRCLK by one BCLK (Philips I2S). The DAC samples on the rising BCLK edge.
- Frame boundary (fall event where the new `bit_cnt` is 0):
  - `hold` loads `i_mute ? 0 : i_sample`.
  - `o_sample_strobe` is 1 for that single cycle; it is 0 in all other cycles.
  - `o_sdata` at `bit_cnt` 1 uses the newly loaded `hold`.
- `i_sample` and `i_mute` are ignored outside the frame boundary, so mid-frame changes never alter the frame in flight.
- Signed values are serialized bit-exact: no rounding or saturation, and the pad bits are zero.

## Timing
- Reset (`i_reset_n` low at a rising edge) sets:
  - `div_cnt = 0`, `bit_cnt = 2·SLOT_W-1`, `hold = 0`.
  - `o_bclk = 0`, `o_lrclk = 0`, `o_sdata = 0`, `o_sample_strobe = 0`.
- Reset asserted mid-frame takes effect at the next edge and discards the frame in flight. It has priority over all other events.
- After release:
  - First rising BCLK at `CLK_DIV` cycles.
  - First fall event, first strobe and first `hold` load at 2·`CLK_DIV` cycles.
- Periods:
  - BCLK period = 2·`CLK_DIV` cycles, 50% duty.
  - Frame = strobe spacing = LRCLK period = 4·`SLOT_W`·`CLK_DIV` cycles (1024 at default).
  - LRCLK duty is 50%.
- Latency from strobe to the first data bit (left MSB) = 2·`CLK_DIV` cycles. The full sample is out within one frame.
- `o_bclk`, `o_lrclk` and `o_sdata` change only on the same clock edge (a fall event); `o_lrclk` and `o_sdata` are stable across every rising BCLK.

## Structure
- Shared package `synth_pkg`: `SAMPLE_W` (24, also used by `voice_controller`), `SLOT_W` (32), `BCLK_DIV` (8).
- One sub-module, `i2s_bclk_gen`:
  - Contains `div_cnt` and the `o_bclk` toggle.
  - Outputs `o_bclk` and a one-cycle `o_fall` event.
- The top level holds `bit_cnt`, `hold`, the data mux and the strobe.

## Test plan
- **Reset:** hold `i_reset_n` low for 10 cycles → all outputs 0. After release, the first `o_bclk` rise is at cycle 8 and the first `o_sample_strobe` at cycle 16.
- **Periods:** free run for 4 frames → strobes exactly 1024 cycles apart, `o_bclk` period 16, `o_lrclk` high for 512 and low for 512 cycles. `o_lrclk` falls in the strobe cycle.
- **Bit order:** `i_sample = 24'h800001` → left bits 1..24 = 1, then 22 zeros, then 1. Right bits 33..56 are identical. Bits 0, 25..32 and 57..63 are 0.
- **Mid-frame input change:** `i_sample = 24'h123456` at the strobe, then `24'hFFFFFF` one cycle later → the frame carries `123456`. The next frame carries `FFFFFF`.
- **Mute:** assert `i_mute` mid-frame with `i_sample = 24'h7FFFFF` → the current frame is still `7FFFFF`. The next frame is all zeros and the strobe still pulses.
- **Reset mid-frame:** assert `i_reset_n = 0` at `bit_cnt` 40 → the next edge shows all outputs 0. After release, the timing matches the reset scenario.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared audio-path constants for the mixer and the I2S serializer, plus a
// small width helper used to size counters.
package synth_pkg;

   localparam int SAMPLE_W = 24;
   localparam int SLOT_W   = 32;
   localparam int BCLK_DIV = 8;

   // Counter width for values 0..n-1, never less than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: toggles o_bclk every CLK_DIV cycles and flags the
// cycle in which the toggle takes BCLK from high to low.
module i2s_bclk_gen #(
   parameter int CLK_DIV = synth_pkg::BCLK_DIV
) (
   input  logic i_clk,
   input  logic i_reset_n,
   output logic o_bclk,
   output logic o_fall
);
   import synth_pkg::*;

   localparam int               DIV_W    = width_of(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             wrap;

   assign wrap   = (div_cnt == DIV_LAST);
   // Combinational so the top updates LRCLK/SDATA on the same edge BCLK falls.
   assign o_fall = wrap & o_bclk;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         div_cnt <= '0;
         o_bclk  <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         o_bclk  <= ~o_bclk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: latches one mono sample per frame, strobes
// the mixer, and serializes the sample MSB first into both channel slots.
module i2s_tx #(
   parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
   parameter int SLOT_W   = synth_pkg::SLOT_W,
   parameter int CLK_DIV  = synth_pkg::BCLK_DIV
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic signed [SAMPLE_W-1:0] i_sample,
   input  logic                       i_mute,
   output logic                       o_sample_strobe,
   output logic                       o_bclk,
   output logic                       o_lrclk,
   output logic                       o_sdata
);
   import synth_pkg::*;

   localparam int               CNT_W     = width_of(2 * SLOT_W);
   localparam int               IDX_W     = width_of(SAMPLE_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * SLOT_W - 1);
   localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_W);

   logic                fall;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic [SAMPLE_W-1:0] hold;
   logic [SAMPLE_W-1:0] hold_next;
   logic                data_next;
   int                  pos;

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bclk_gen (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .o_bclk    (o_bclk),
      .o_fall    (fall)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      cnt_next  = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
      hold_next = (cnt_next == '0) ? (i_mute ? '0 : i_sample) : hold;
      pos       = int'(cnt_next);
      data_next = 1'b0;
      // Bit 0 of each slot is the Philips one-BCLK delay; tail bits are zero pad.
      if (pos >= 1 && pos <= SAMPLE_W) begin
         data_next = hold[IDX_W'(SAMPLE_W - pos)];
      end else if (pos >= SLOT_W + 1 && pos <= SLOT_W + SAMPLE_W) begin
         data_next = hold[IDX_W'(SLOT_W + SAMPLE_W - pos)];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bit_cnt         <= CNT_LAST;
         hold            <= '0;
         o_lrclk         <= 1'b0;
         o_sdata         <= 1'b0;
         o_sample_strobe <= 1'b0;
      end else begin
         o_sample_strobe <= 1'b0;
         if (fall) begin
            bit_cnt         <= cnt_next;
            hold            <= hold_next;
            o_lrclk         <= (cnt_next >= CNT_RIGHT);
            o_sdata         <= data_next;
            o_sample_strobe <= (cnt_next == '0);
         end
      end
   end

endmodule
